i2c_cmd_arbiter: RTL

Round-robin arbiter that shares one I2C master command port between NUM_REQ requesters (EEPROM Avalon bridge, sensor pollers, and similar clients). Each requester keeps the command/data handshake it would use against the master directly, plus a req/gnt pair. The arbiter grants one requester at a time, muxes its command and write-data path to the master, and routes read data, strobes and busy back to it. A grant is held until the launched command completes, or across several commands under lock.

---
 rtl/i2c_cmd_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sharing one I2C master command port
//
// Purpose: grants one of NUM_REQ requesters at a time to a single I2C master,
// muxing that requester's command/write-data path to the master and routing
// master status (read strobe, data valid, busy) back to it. A grant is held
// until the launched command completes, or across commands while lock_i is
// held when the I2C_ARB_LOCK_EN macro is defined (default build: lock ignored).
//
// Ports:
//   clock_i, reset_i           clock, asynchronous active-low reset
//   req_i, lock_i, gnt_o       per-requester request, lock, one-hot grant
//   cmd_strobe_i, ctrl_wrd_i, len_read_i, data_available_i, data_i, ack_error_i
//                              per-requester command side (bytes packed k*8)
//   read_data_o, data_valid_o, rd_data_o, busy_o
//                              per-requester status side (rd_data_o broadcast)
//   drop_o                     sticky: a non-forwarded strobe was discarded
//   i2c_*_o / i2c_*_i          master command / status side
module i2c_cmd_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     lock_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  input  logic [NUM_REQ-1:0]     cmd_strobe_i,
  input  logic [8*NUM_REQ-1:0]   ctrl_wrd_i,
  input  logic [8*NUM_REQ-1:0]   len_read_i,
  input  logic [NUM_REQ-1:0]     data_available_i,
  input  logic [8*NUM_REQ-1:0]   data_i,
  input  logic [NUM_REQ-1:0]     ack_error_i,
  output logic [NUM_REQ-1:0]     read_data_o,
  output logic [NUM_REQ-1:0]     data_valid_o,
  output logic [7:0]             rd_data_o,
  output logic [NUM_REQ-1:0]     busy_o,
  output logic [NUM_REQ-1:0]     drop_o,
  output logic                   i2c_cmd_strobe_o,
  output logic [7:0]             i2c_ctrl_wrd_o,
  output logic [7:0]             i2c_len_read_o,
  output logic                   i2c_data_available_o,
  output logic [7:0]             i2c_data_o,
  output logic                   i2c_ack_error_o,
  input  logic                   i2c_read_data_i,
  input  logic [7:0]             i2c_data_i,
  input  logic                   i2c_data_valid_i,
  input  logic                   i2c_busy_i
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANTED, LAUNCH, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] drop_q, drop_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_found;
  logic               has_gnt;
  logic               sel_req;
  logic               sel_strobe;
  logic               lock_keep;

  assign has_gnt    = |gnt_q;
  assign sel_req    = |(req_i & gnt_q);
  assign sel_strobe = |(cmd_strobe_i & gnt_q);

`ifdef I2C_ARB_LOCK_EN
  assign lock_keep = |(lock_i & req_i & gnt_q);
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign lock_keep   = 1'b0;
`endif

  // First requester at or above rr_ptr, wrapping; outer loop is the search distance.
  always_comb begin
    pick_gnt   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pick_found && req_i[k] && (k == (int'(rr_ptr_q) + i) % NUM_REQ)) begin
          pick_found  = 1'b1;
          pick_gnt[k] = 1'b1;
        end
      end
    end
  end

  // Pointer value after releasing the current owner: one past it, wrapped.
  always_comb begin
    next_ptr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) next_ptr = PW'((k + 1) % NUM_REQ);
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found && !i2c_busy_i) begin
          gnt_d   = pick_gnt;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (sel_strobe) begin
          state_d = LAUNCH;
        end else if (!sel_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      // The master raises busy up to one cycle after the strobe, so busy is
      // not trusted until ACTIVE.
      LAUNCH: state_d = ACTIVE;
      ACTIVE: begin
        if (!i2c_busy_i) begin
          if (lock_keep) begin
            state_d = GRANTED;
          end else begin
            gnt_d    = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Only the owner's strobe in GRANTED is forwarded; everything else is dropped.
  assign drop_d = drop_q | (cmd_strobe_i & ~((state_q == GRANTED) ? gnt_q : '0));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    i2c_cmd_strobe_o     = 1'b0;
    i2c_ctrl_wrd_o       = 8'h00;
    i2c_len_read_o       = 8'h00;
    i2c_data_available_o = 1'b0;
    i2c_data_o           = 8'h00;
    i2c_ack_error_o      = 1'b0;
    read_data_o          = '0;
    data_valid_o         = '0;
    busy_o               = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        i2c_cmd_strobe_o     = cmd_strobe_i[k] & (state_q == GRANTED);
        i2c_ctrl_wrd_o       = ctrl_wrd_i[k*8 +: 8];
        i2c_len_read_o       = len_read_i[k*8 +: 8];
        i2c_data_available_o = data_available_i[k];
        i2c_data_o           = data_i[k*8 +: 8];
        i2c_ack_error_o      = ack_error_i[k];
        read_data_o[k]       = i2c_read_data_i;
        data_valid_o[k]      = i2c_data_valid_i;
        busy_o[k]            = i2c_busy_i | (state_q == LAUNCH);
      end else begin
        // Non-owners see the master as busy for the whole grant period.
        busy_o[k] = has_gnt | i2c_busy_i;
      end
    end
  end

  assign gnt_o     = gnt_q;
  assign drop_o    = drop_q;
  assign rd_data_o = i2c_data_i;

endmodule
